// File: rtl/ps2_kbd_pkg.sv
// ps2_kbd_pkg: keyboard command bytes, controller state encoding and helpers
package ps2_kbd_pkg;

    localparam logic [7:0] KBD_RESET    = 8'hFF;
    localparam logic [7:0] KBD_SETLED   = 8'hED;
    localparam logic [7:0] KBD_ACK      = 8'hFA;
    localparam logic [7:0] KBD_RESEND   = 8'hFE;
    localparam logic [7:0] KBD_BAT_OK   = 8'hAA;
    localparam logic [7:0] KBD_BAT_FAIL = 8'hFC;

    localparam logic [3:0] ST_RST_TX   = 4'd0;
    localparam logic [3:0] ST_RST_ACK  = 4'd1;
    localparam logic [3:0] ST_BAT_WAIT = 4'd2;
    localparam logic [3:0] ST_IDLE     = 4'd3;
    localparam logic [3:0] ST_LED_TX1  = 4'd4;
    localparam logic [3:0] ST_LED_ACK1 = 4'd5;
    localparam logic [3:0] ST_LED_TX2  = 4'd6;
    localparam logic [3:0] ST_LED_ACK2 = 4'd7;
    localparam logic [3:0] ST_ERROR    = 4'd8;

    typedef enum logic [3:0] {
        RST_TX   = ST_RST_TX,
        RST_ACK  = ST_RST_ACK,
        BAT_WAIT = ST_BAT_WAIT,
        IDLE     = ST_IDLE,
        LED_TX1  = ST_LED_TX1,
        LED_ACK1 = ST_LED_ACK1,
        LED_TX2  = ST_LED_TX2,
        LED_ACK2 = ST_LED_ACK2,
        ERROR    = ST_ERROR
    } kbd_state_t;

    // LED data byte layout expected by the keyboard: {5'b0, caps, num, scroll}
    function automatic logic [7:0] led_byte(input logic [2:0] leds);
        return {5'b0, leds};
    endfunction

endpackage

// File: rtl/ps2_kbd_ctrl_if.sv
// ps2_kbd_ctrl_if: LED request, transceiver command/receive and scancode stream signals
interface ps2_kbd_ctrl_if;

    logic [2:0] leds;
    logic       led_update;
    logic       led_busy;
    logic       init_done;
    logic       init_error;
    logic [7:0] ps2_cmd;
    logic       ps2_send;
    logic       ps2_sent;
    logic       ps2_tmo;
    logic [7:0] ps2_rx;
    logic       ps2_rx_en;
    logic [7:0] scan_data;
    logic       scan_valid;
    logic       scan_ready;
    logic       scan_ovf;

    modport slave (
        input  leds, led_update, ps2_sent, ps2_tmo, ps2_rx, ps2_rx_en, scan_ready,
        output led_busy, init_done, init_error, ps2_cmd, ps2_send, scan_data, scan_valid, scan_ovf
    );

    modport master (
        output leds, led_update, ps2_sent, ps2_tmo, ps2_rx, ps2_rx_en, scan_ready,
        input  led_busy, init_done, init_error, ps2_cmd, ps2_send, scan_data, scan_valid, scan_ovf
    );

endinterface

// File: rtl/ps2_scan_fifo.sv
// ps2_scan_fifo: synchronous scancode FIFO with show-ahead head and sticky overflow
module ps2_scan_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             ovf
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             full;
    logic             do_pop;
    logic             do_push;

    // a full FIFO still accepts a push when a pop frees a slot in the same cycle
    always_comb begin
        full    = count == (AW+1)'(DEPTH);
        empty   = count == '0;
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        dout    = mem[rd_ptr];
    end

    // storage is written only on an accepted push and needs no reset
    always_ff @(posedge CLOCK_50)
        if (do_push) mem[wr_ptr] <= din;

    // pointers, occupancy and the sticky drop flag
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
            if (push && !do_push) ovf <= 1'b1;
        end
    end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl: keyboard init/LED command sequencer with scancode routing into a FIFO
module ps2_kbd_ctrl
    import ps2_kbd_pkg::*;
#(
    parameter int ACK_TIMEOUT = 1000000,
    parameter int MAX_RETRY   = 3,
    parameter int FIFO_DEPTH  = 8
) (
    input logic           CLOCK_50,
    input logic           reset,
    ps2_kbd_ctrl_if.slave bus
);

    localparam int TW = $clog2(ACK_TIMEOUT);
    localparam int RW = $clog2(MAX_RETRY + 1);

    kbd_state_t    state;
    kbd_state_t    tx_next;
    kbd_state_t    ack_next;
    kbd_state_t    ack_tx;
    logic [TW-1:0] tmo_cnt;
    logic [RW-1:0] retry_cnt;
    logic [2:0]    led_shadow;
    logic [7:0]    tx_byte;
    logic          pending;
    logic          is_ack;
    logic          is_led;
    logic          is_wait;
    logic          tmo_exp;
    logic          retry_max;
    logic          rx_ack;
    logic          rx_resend;
    logic          rx_bat_ok;
    logic          rx_bat_fail;
    logic          consume;
    logic          push;
    logic          fifo_empty;

    // state decode, byte classification and routing of received bytes
    always_comb begin
        is_ack      = state inside {RST_ACK, LED_ACK1, LED_ACK2};
        is_led      = state inside {LED_TX1, LED_ACK1, LED_TX2, LED_ACK2};
        is_wait     = is_ack || state == BAT_WAIT;
        tmo_exp     = tmo_cnt == TW'(ACK_TIMEOUT - 1);
        retry_max   = int'(retry_cnt) >= MAX_RETRY;
        rx_ack      = bus.ps2_rx_en && bus.ps2_rx == KBD_ACK;
        rx_resend   = bus.ps2_rx_en && bus.ps2_rx == KBD_RESEND;
        rx_bat_ok   = bus.ps2_rx_en && bus.ps2_rx == KBD_BAT_OK;
        rx_bat_fail = bus.ps2_rx_en && bus.ps2_rx == KBD_BAT_FAIL;
        tx_byte     = state == RST_TX ? KBD_RESET : state == LED_TX1 ? KBD_SETLED : led_byte(led_shadow);
        tx_next     = state == RST_TX ? RST_ACK : state == LED_TX1 ? LED_ACK1 : LED_ACK2;
        ack_next    = state == RST_ACK ? BAT_WAIT : state == LED_ACK1 ? LED_TX2 : IDLE;
        ack_tx      = state == RST_ACK ? RST_TX : state == LED_ACK1 ? LED_TX1 : LED_TX2;
        consume     = is_ack ? (rx_ack || rx_resend) :
                      state == BAT_WAIT ? (rx_bat_ok || rx_bat_fail) :
                      state == IDLE ? rx_bat_ok : state == ERROR;
        push        = bus.ps2_rx_en && !consume;
    end

    assign bus.led_busy   = is_led || pending;
    assign bus.scan_valid = !fifo_empty;

    // command sequencer: send handshake, ack/BAT waits, retries and LED request queueing
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state          <= RST_TX;
            bus.ps2_send   <= 1'b0;
            bus.ps2_cmd    <= 8'h00;
            bus.init_done  <= 1'b0;
            bus.init_error <= 1'b0;
            tmo_cnt        <= '0;
            retry_cnt      <= '0;
            pending        <= 1'b0;
            led_shadow     <= '0;
        end else begin
            tmo_cnt <= is_wait ? tmo_cnt + 1'b1 : '0;
            if (bus.led_update && state != IDLE && state != ERROR) pending <= 1'b1;
            case (state)
                RST_TX, LED_TX1, LED_TX2: begin
                    bus.ps2_cmd <= tx_byte;
                    if (bus.ps2_send && bus.ps2_sent) begin
                        bus.ps2_send <= 1'b0;
                        state        <= tx_next;
                    end else if (bus.ps2_send && bus.ps2_tmo) begin
                        bus.ps2_send <= 1'b0;
                        retry_cnt    <= retry_cnt + 1'b1;
                        if (retry_max) state <= ERROR;
                    end else begin
                        bus.ps2_send <= 1'b1;
                    end
                end
                RST_ACK, LED_ACK1, LED_ACK2: begin
                    if (rx_ack) begin
                        state     <= ack_next;
                        retry_cnt <= '0;
                        tmo_cnt   <= '0;
                    end else if (rx_resend || tmo_exp) begin
                        state     <= retry_max ? ERROR : ack_tx;
                        retry_cnt <= retry_cnt + 1'b1;
                    end
                end
                BAT_WAIT: begin
                    if (rx_bat_ok) begin
                        bus.init_done <= 1'b1;
                        state         <= IDLE;
                    end else if (rx_bat_fail || tmo_exp) begin
                        state <= ERROR;
                    end
                end
                IDLE: begin
                    if (pending || bus.led_update) begin
                        led_shadow <= bus.leds;
                        pending    <= 1'b0;
                        retry_cnt  <= '0;
                        state      <= LED_TX1;
                    end else if (rx_bat_ok) begin
                        pending <= 1'b1;
                    end
                end
                default: begin
                    bus.ps2_send   <= 1'b0;
                    bus.init_done  <= 1'b0;
                    bus.init_error <= 1'b1;
                    pending        <= 1'b0;
                end
            endcase
        end
    end

    ps2_scan_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(8)
    ) u_fifo (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .push    (push),
        .din     (bus.ps2_rx),
        .pop     (bus.scan_ready),
        .dout    (bus.scan_data),
        .empty   (fifo_empty),
        .ovf     (bus.scan_ovf)
    );

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb_ps2_kbd_ctrl: directed keyboard/transceiver scenarios against ps2_kbd_ctrl
module tb_ps2_kbd_ctrl;
    import ps2_kbd_pkg::*;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   tx_cnt [256];
    int   tmo_ff_cnt = 0;
    bit   prev_send   = 1'b0;
    bit   prev_send_t = 1'b0;

    ps2_kbd_ctrl_if bus();
    ps2_kbd_ctrl_if bus_t();

    ps2_kbd_ctrl #(.ACK_TIMEOUT(10000), .MAX_RETRY(3), .FIFO_DEPTH(8)) u_dut (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .bus     (bus)
    );

    ps2_kbd_ctrl #(.ACK_TIMEOUT(100), .MAX_RETRY(3), .FIFO_DEPTH(8)) u_tmo (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .bus     (bus_t)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // count each new transmission (rising ps2_send) per command byte
    always @(negedge CLOCK_50) begin
        if (bus.ps2_send && !prev_send) tx_cnt[bus.ps2_cmd] += 1;
        if (bus_t.ps2_send && !prev_send_t && bus_t.ps2_cmd == KBD_RESET) tmo_ff_cnt += 1;
        prev_send   = bus.ps2_send;
        prev_send_t = bus_t.ps2_send;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic wait_send(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge CLOCK_50);
            ok = bus.ps2_send;
        end
    endtask

    task automatic wait_send_t(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge CLOCK_50);
            ok = bus_t.ps2_send;
        end
    endtask

    task automatic expect_tx(input string tag, input logic [7:0] b);
        bit ok;
        wait_send(ok);
        check({tag, "_sent"}, ok, 1);
        check(tag, bus.ps2_cmd, b);
        if (ok) begin
            bus.ps2_sent = 1'b1;
            cycles(1);
            bus.ps2_sent = 1'b0;
        end
    endtask

    task automatic rx_byte(input logic [7:0] b);
        bus.ps2_rx    = b;
        bus.ps2_rx_en = 1'b1;
        cycles(1);
        bus.ps2_rx_en = 1'b0;
    endtask

    task automatic pulse_led(input logic [2:0] l);
        bus.leds       = l;
        bus.led_update = 1'b1;
        cycles(1);
        bus.led_update = 1'b0;
    endtask

    task automatic do_init(input int bat_delay);
        expect_tx("init_rst", KBD_RESET);
        rx_byte(KBD_ACK);
        cycles(bat_delay);
        rx_byte(KBD_BAT_OK);
    endtask

    initial begin
        bit   ok;
        int   base;
        int   base2;
        logic [7:0] exp_b;
        bus.leds = '0; bus.led_update = 0; bus.ps2_sent = 0; bus.ps2_tmo = 0;
        bus.ps2_rx = '0; bus.ps2_rx_en = 0; bus.scan_ready = 0;
        bus_t.leds = '0; bus_t.led_update = 0; bus_t.ps2_sent = 0; bus_t.ps2_tmo = 0;
        bus_t.ps2_rx = '0; bus_t.ps2_rx_en = 0; bus_t.scan_ready = 0;
        cycles(3);
        check("rst_send", bus.ps2_send, 0);
        check("rst_cmd", bus.ps2_cmd, 8'h00);
        check("rst_done", bus.init_done, 0);
        check("rst_err", bus.init_error, 0);
        check("rst_busy", bus.led_busy, 0);
        check("rst_valid", bus.scan_valid, 0);
        check("rst_ovf", bus.scan_ovf, 0);
        base = tx_cnt[KBD_RESET];
        reset = 1'b0;
        do_init(5000);
        check("init_done", bus.init_done, 1);
        check("init_ff_count", tx_cnt[KBD_RESET] - base, 1);
        check("init_fifo_empty", bus.scan_valid, 0);
        check("init_busy", bus.led_busy, 0);

        pulse_led(3'b101);
        check("led_busy_start", bus.led_busy, 1);
        expect_tx("led_cmd", KBD_SETLED);
        rx_byte(KBD_ACK);
        expect_tx("led_data", 8'h05);
        pulse_led(3'b010);
        bus.leds = 3'b011;
        rx_byte(KBD_ACK);
        check("led_pending_busy", bus.led_busy, 1);
        expect_tx("led_cmd2", KBD_SETLED);
        rx_byte(KBD_ACK);
        expect_tx("led_data2", 8'h03);
        check("led_busy_mid", bus.led_busy, 1);
        rx_byte(KBD_ACK);
        check("led_busy_end", bus.led_busy, 0);
        check("led_no_err", bus.init_error, 0);

        base  = tx_cnt[KBD_SETLED];
        base2 = tx_cnt[8'h01];
        pulse_led(3'b001);
        expect_tx("rs_cmd", KBD_SETLED);
        rx_byte(KBD_ACK);
        expect_tx("rs_data1", 8'h01);
        rx_byte(KBD_RESEND);
        expect_tx("rs_data2", 8'h01);
        rx_byte(KBD_RESEND);
        expect_tx("rs_data3", 8'h01);
        rx_byte(KBD_ACK);
        check("rs_ed_count", tx_cnt[KBD_SETLED] - base, 1);
        check("rs_data_count", tx_cnt[8'h01] - base2, 3);
        check("rs_idle_busy", bus.led_busy, 0);
        check("rs_no_err", bus.init_error, 0);

        pulse_led(3'b100);
        expect_tx("sc_cmd", KBD_SETLED);
        rx_byte(8'h1C);
        check("sc_valid", bus.scan_valid, 1);
        check("sc_data", bus.scan_data, 8'h1C);
        rx_byte(KBD_ACK);
        expect_tx("sc_data_byte", 8'h04);
        rx_byte(KBD_ACK);
        check("sc_busy_end", bus.led_busy, 0);
        bus.scan_ready = 1'b1;
        cycles(1);
        bus.scan_ready = 1'b0;
        check("sc_popped", bus.scan_valid, 0);

        base = tx_cnt[8'h04];
        rx_byte(KBD_BAT_OK);
        check("hp_busy", bus.led_busy, 1);
        check("hp_no_push", bus.scan_valid, 0);
        expect_tx("hp_cmd", KBD_SETLED);
        rx_byte(KBD_ACK);
        expect_tx("hp_data", 8'h04);
        rx_byte(KBD_ACK);
        check("hp_busy_end", bus.led_busy, 0);
        check("hp_fifo_empty", bus.scan_valid, 0);
        check("hp_data_count", tx_cnt[8'h04] - base, 1);

        for (int i = 0; i < 8; i++) rx_byte(8'(8'h10 + i));
        check("ff_full_valid", bus.scan_valid, 1);
        check("ff_full_no_ovf", bus.scan_ovf, 0);
        check("ff_head", bus.scan_data, 8'h10);
        bus.ps2_rx     = 8'h20;
        bus.ps2_rx_en  = 1'b1;
        bus.scan_ready = 1'b1;
        cycles(1);
        bus.ps2_rx_en  = 1'b0;
        bus.scan_ready = 1'b0;
        check("ff_pushpop_no_ovf", bus.scan_ovf, 0);
        check("ff_pushpop_head", bus.scan_data, 8'h11);
        rx_byte(8'h21);
        check("ff_drop_ovf", bus.scan_ovf, 1);
        for (int i = 0; i < 8; i++) begin
            exp_b = (i < 7) ? 8'(8'h11 + i) : 8'h20;
            check($sformatf("ff_order%0d", i), bus.scan_data, exp_b);
            bus.scan_ready = 1'b1;
            cycles(1);
            bus.scan_ready = 1'b0;
        end
        check("ff_drained", bus.scan_valid, 0);

        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        do_init(20);
        check("e4_init", bus.init_done, 1);
        check("e4_ovf_cleared", bus.scan_ovf, 0);
        pulse_led(3'b010);
        expect_tx("e4_cmd", KBD_SETLED);
        rx_byte(KBD_ACK);
        base = tx_cnt[8'h02];
        for (int i = 0; i < 4; i++) begin
            expect_tx($sformatf("e4_data%0d", i), 8'h02);
            rx_byte(KBD_RESEND);
        end
        cycles(2);
        check("e4_data_count", tx_cnt[8'h02] - base, 4);
        check("e4_error", bus.init_error, 1);
        check("e4_done_clr", bus.init_done, 0);
        check("e4_send_low", bus.ps2_send, 0);
        pulse_led(3'b111);
        cycles(5);
        check("e4_led_ignored", bus.led_busy, 0);
        check("e4_no_send", bus.ps2_send, 0);

        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        wait_send(ok);
        check("mid_seen", ok, 1);
        reset = 1'b1;
        cycles(1);
        check("mid_reset_send", bus.ps2_send, 0);
        check("mid_reset_err", bus.init_error, 0);
        reset = 1'b0;
        expect_tx("bf_rst", KBD_RESET);
        rx_byte(KBD_ACK);
        rx_byte(KBD_BAT_FAIL);
        cycles(2);
        check("bf_error", bus.init_error, 1);
        check("bf_done", bus.init_done, 0);
        check("bf_fifo_empty", bus.scan_valid, 0);

        base  = tmo_ff_cnt;
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wait_send_t(ok);
            if (!ok) break;
            check($sformatf("to_cmd%0d", i), bus_t.ps2_cmd, KBD_RESET);
            bus_t.ps2_sent = 1'b1;
            cycles(1);
            bus_t.ps2_sent = 1'b0;
        end
        check("to_ff_count", tmo_ff_cnt - base, 4);
        check("to_error", bus_t.init_error, 1);
        check("to_done", bus_t.init_done, 0);
        check("to_send_low", bus_t.ps2_send, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_ctrl.md
Name: ps2_kbd_ctrl

Overview:
- Command sequencer and receive router that sits directly above the ps2_keyboard transceiver, instantiated with INITIALIZE_MOUSE=0.
- After reset it runs the keyboard initialisation handshake: 0xFF reset command, 0xFA acknowledge, then the 0xAA self-test result (BAT).
- It services LED update requests with the 0xED command followed by one LED data byte, retrying when the keyboard answers with a resend request or a timeout occurs.
- Scancodes that are not part of a command handshake are forwarded to the core through a small FIFO.

Parameters:
- ACK_TIMEOUT, 1000000, cycles to wait for an ACK or BAT byte (20 ms at 50 MHz).
- MAX_RETRY, 3, maximum resends of a single byte before entering the error state.
- FIFO_DEPTH, 8, scancode FIFO depth; must be a power of 2.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  synchronous, active-high.
- leds  in  3  {caps, num, scroll}.
- led_update  in  1  single-cycle pulse requesting that leds be sent to the keyboard.
- led_busy  out  1  LED sequence in progress or pending.
- init_done  out  1  keyboard initialised.
- init_error  out  1  sticky failure flag.
- ps2_cmd  out  8  connects to the transceiver's the_command.
- ps2_send  out  1  connects to send_command.
- ps2_sent  in  1  connects to command_was_sent.
- ps2_tmo  in  1  connects to error_communication_timed_out.
- ps2_rx  in  8  connects to received_data.
- ps2_rx_en  in  1  connects to received_data_en; one-cycle strobe.
- scan_data  out  8  FIFO head byte.
- scan_valid  out  1  FIFO not empty.
- scan_ready  in  1  pop request; a pop happens when scan_valid and scan_ready are both high.
- scan_ovf  out  1  sticky flag: a byte was dropped because the FIFO was full.

Behaviour:
- Reset is synchronous, active-high, clocked by CLOCK_50.
- Reset values of registered outputs: ps2_send=0, ps2_cmd=0x00, init_done=0, init_error=0, led_busy=0, scan_ovf=0, scan_valid=0.
  - scan_data is the FIFO head and is not defined while scan_valid=0.
  - The FIFO, retry counter, timeout counter, pending flag and LED shadow register are all cleared.
- State machine, leaving reset in RST_TX:
  - RST_TX: ps2_cmd=0xFF, ps2_send=1. On ps2_sent go to RST_ACK. On ps2_tmo, retry.
  - RST_ACK: 0xFA goes to BAT_WAIT. 0xFE or timeout, retry.
  - BAT_WAIT: 0xAA sets init_done=1 and goes to IDLE. 0xFC goes to ERROR. Timeout goes to ERROR (no resend).
  - IDLE: a pending request, or led_update, captures leds into the shadow register and goes to LED_TX1.
  - LED_TX1: sends 0xED, then LED_ACK1.
  - LED_ACK1: on 0xFA go to LED_TX2.
  - LED_TX2: sends {5'b0, caps, num, scroll}, then LED_ACK2.
  - LED_ACK2: on 0xFA go to IDLE.
  - ERROR: init_error=1, init_done=0, ps2_send=0. The block stays in ERROR until reset; led_update is ignored.
- Send handshake (all *_TX states):
  - ps2_send is registered and held high with ps2_cmd stable until ps2_sent or ps2_tmo.
  - ps2_send drops on the following cycle and stays low for at least 1 cycle before any new send.
- Retry rule:
  - A retry re-enters the same *_TX state with the same byte and increments the retry counter.
  - In LED_ACK2, 0xFE resends only the data byte. Timeout also resends only that byte.
  - When the retry counter would exceed MAX_RETRY, go to ERROR.
  - The retry counter clears on every accepted 0xFA.
- Ack timeout counter: clears on entry to any *_ACK or BAT_WAIT state. It expires when it reaches ACK_TIMEOUT-1 without a matching byte.
- Receive routing, evaluated on each ps2_rx_en:
  - In *_ACK states, 0xFA and 0xFE are consumed. In BAT_WAIT, 0xAA and 0xFC are consumed.
  - Every other byte, in any state except ERROR, is pushed into the FIFO.
  - In IDLE, 0xAA (keyboard hot-plug) is consumed and sets the pending flag so the current LED state is restored.
- led_update arriving outside IDLE (including during init) sets the pending flag. Multiple requests collapse into one.
  - The LED value used is the leds input sampled on leaving IDLE, not at request time.
- led_busy=1 whenever the state is LED_* or the pending flag is set.
- FIFO:
  - Push and pop in the same cycle while full is allowed: both occur and no overflow is flagged.
  - Push while full without a pop drops the byte and sets scan_ovf.
  - scan_data is the head byte with zero added latency: valid in the same cycle scan_valid is high.
  - Push while empty makes scan_valid=1 on the next cycle.
- A reset mid-transfer immediately drops ps2_send and restarts from RST_TX.

Decomposition:
- Package ps2_kbd_pkg holds:
  - Byte constants: KBD_RESET=0xFF, KBD_SETLED=0xED, KBD_ACK=0xFA, KBD_RESEND=0xFE, KBD_BAT_OK=0xAA, KBD_BAT_FAIL=0xFC.
  - The state encoding localparams.
- One sub-module, ps2_scan_fifo: a synchronous FIFO parameterised by depth and width 8, with push, pop, full, empty and overflow.

Test Plan:
- Init with a keyboard model:
  - Send 0xFF, the model acks 0xFA, then sends 0xAA after 5000 cycles.
  - Required: init_done=1, exactly one 0xFF transmitted, FIFO empty.
- LED update:
  - leds=3'b101 with a led_update pulse in IDLE.
  - Required: 0xED then 0x05 transmitted, each acked; led_busy falls after the second 0xFA.
- Resend on data byte:
  - The model answers 0xFE twice to the LED byte.
  - Required: the byte is transmitted 3 times, 0xED only once, ending in IDLE.
  - Variant: 4 consecutive 0xFE, required init_error=1.
- Init failures:
  - The model sends 0xFC for BAT: required ERROR, init_error=1.
  - No ACK ever (ACK_TIMEOUT=100 in the bench): required 4 transmissions of 0xFF, then init_error=1.
- Scancode routing:
  - 0x1C arrives during LED_ACK1, before 0xFA: required 0x1C appears on scan_data and the handshake still completes.
  - 0xAA arrives in IDLE: required the LED sequence reruns and the FIFO receives nothing.
- FIFO:
  - 9 bytes pushed with scan_ready=0: required 8 stored and scan_ovf=1.
  - Simultaneous push and pop while full: required no overflow and order preserved.
